// File: rtl/uart_tx_arbiter_if.sv
// Requester/Sender bundle for uart_tx_arbiter: requester side (req, req_data, gnt, done,
// err, busy) and the four-phase Sender handshake (XMT_REQ, XMT_DATA, XMT_ACK).
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic                 err;
    logic                 busy;
    logic                 XMT_REQ;
    logic [7:0]           XMT_DATA;
    logic                 XMT_ACK;

    modport master (
        input  req, req_data, XMT_ACK,
        output gnt, done, err, busy, XMT_REQ, XMT_DATA
    );

    modport slave (
        output req, req_data, XMT_ACK,
        input  gnt, done, err, busy, XMT_REQ, XMT_DATA
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART Sender among NUM_REQ byte requesters through a
// four-phase XMT_REQ/XMT_ACK handshake, with a per-phase timeout that aborts to ERR.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              clr,
    uart_tx_arbiter_if.master bus
);
    localparam int               IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [11:0]      TIMEOUT_C = 12'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RELEASE,
        ERR
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   last_gnt_q;
    logic [IDX_W-1:0]   cur_idx_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic               err_q;
    logic               busy_q;
    logic               xmt_req_q;
    logic [7:0]         xmt_data_q;
    logic [11:0]        cnt_q;
    logic [11:0]        cnt_d;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    int                 sum;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [7:0]         pick_data;

    // Search upward from last_gnt+1 with wrap; the first requester found wins.
    always_comb begin
        // NOTE: every signal gets a default before the loop so no path leaves one unassigned and infers a latch.
        pick_vld = 1'b0;
        pick_idx = last_gnt_q;
        sum      = 0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = int'(last_gnt_q) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = IDX_W'(sum);
            if (!pick_vld && bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign pick_onehot = NUM_REQ'(1) << pick_idx;
    assign pick_data   = bus.req_data[{pick_idx, 3'b000} +: 8];
    assign cnt_d       = cnt_q + 12'd1;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (clr) begin
            state_q    <= IDLE;
            last_gnt_q <= LAST_IDX;
            cur_idx_q  <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            xmt_req_q  <= 1'b0;
            xmt_data_q <= 8'h00;
            cnt_q      <= 12'd0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q    <= SEND;
                        busy_q     <= 1'b1;
                        xmt_req_q  <= 1'b1;
                        xmt_data_q <= pick_data;
                        gnt_q      <= pick_onehot;
                        cur_idx_q  <= pick_idx;
                        cnt_q      <= 12'd0;
                    end else begin
                        busy_q     <= 1'b0;
                        xmt_req_q  <= 1'b0;
                        xmt_data_q <= 8'h00;
                        gnt_q      <= '0;
                    end
                end
                SEND: begin
                    if (bus.XMT_ACK) begin
                        state_q   <= RELEASE;
                        xmt_req_q <= 1'b0;
                        cnt_q     <= 12'd0;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_q    <= ERR;
                        err_q      <= 1'b1;
                        xmt_req_q  <= 1'b0;
                        xmt_data_q <= 8'h00;
                        gnt_q      <= '0;
                        last_gnt_q <= cur_idx_q;
                        cnt_q      <= 12'd0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RELEASE: begin
                    if (!bus.XMT_ACK) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= gnt_q;
                        gnt_q      <= '0;
                        xmt_data_q <= 8'h00;
                        last_gnt_q <= cur_idx_q;
                        cnt_q      <= 12'd0;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_q    <= ERR;
                        err_q      <= 1'b1;
                        xmt_data_q <= 8'h00;
                        gnt_q      <= '0;
                        last_gnt_q <= cur_idx_q;
                        cnt_q      <= 12'd0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ERR: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
    assign bus.XMT_REQ  = xmt_req_q;
    assign bus.XMT_DATA = xmt_data_q;
endmodule
